// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch
// port and the load/store port, one transaction in flight at a time.
//
// Ports
//   clk, rst_n       clock, async active-low reset
//   if_*             fetch requester (req/addr in, gnt/rvalid/rdata out)
//   d_*              load/store requester (req/we/addr/wdata/wmask in,
//                    gnt/rvalid/rdata out)
//   mem_*            memory side (req/we/addr/wdata/wmask out,
//                    gnt/rvalid/rdata in)
//   spurious_rsp     sticky flag: response seen with nothing in flight
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                spurious_rsp
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } state_t;

  state_t             state;
  logic               owner_d;
  logic [CNT_W-1:0]   starve_cnt;
  logic               starved;
  logic               pick_d;
  logic               pick_f;
  logic               rsp_hit;

  assign starved = (starve_cnt == CNT_MAX);

  // Data wins ties unless fetch has already waited out its allowance.
  always_comb begin
    pick_d = 1'b0;
    pick_f = 1'b0;
    unique case (1'b1)
      d_req && !(if_req && starved):  pick_d = 1'b1;
      if_req && !(d_req && !starved): pick_f = 1'b1;
      default: ;
    endcase
  end

  // Grants are combinational in IDLE; rst_n gating keeps them low
  // while reset is held even if requests are up.
  assign d_gnt  = rst_n && (state == IDLE) && pick_d;
  assign if_gnt = rst_n && (state == IDLE) && pick_f;

  assign rsp_hit   = (state == WAIT_RSP) && mem_rvalid;
  assign d_rvalid  = rsp_hit && owner_d;
  assign if_rvalid = rsp_hit && !owner_d;
  assign d_rdata   = mem_rdata;
  assign if_rdata  = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      starve_cnt   <= '0;
      spurious_rsp <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
    end else begin
      if (mem_rvalid && (state != WAIT_RSP))
        spurious_rsp <= 1'b1;
      unique case (state)
        IDLE: begin
          if (d_gnt) begin
            state     <= ISSUE;
            mem_req   <= 1'b1;
            owner_d   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wmask <= d_wmask;
            if (!if_req)
              starve_cnt <= '0;
            else if (!starved)
              starve_cnt <= starve_cnt + CNT_W'(1);
          end else if (if_gnt) begin
            state      <= ISSUE;
            mem_req    <= 1'b1;
            owner_d    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_wmask  <= {MASK_W{1'b0}};
            starve_cnt <= '0;
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            state   <= WAIT_RSP;
            mem_req <= 1'b0;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid)
            state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transactions against a
// transaction-level model of arbitration, fairness and response routing.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [MW-1:0] d_wmask;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          spurious_rsp;

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_gnt(if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_wmask(d_wmask),
    .d_gnt(d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .spurious_rsp(spurious_rsp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  // Model: data grants in a row that fetch has sat through.
  int streak = 0;
  bit spur_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    chk("idle_gnt", {if_gnt, d_gnt}, 0);
    chk("idle_mreq", mem_req, 0);
    chk("idle_rv", {if_rvalid, d_rvalid}, 0);
    chk("idle_spur", spurious_rsp, spur_exp);
    step();
  endtask

  // One full transaction from the IDLE grant cycle to the response.
  // gd: cycles of mem_gnt backpressure; rd: extra cycles before rvalid.
  // keep: winner issues a follow-on request (addr+4) right after gnt.
  task automatic txn(input int gd, input int rd, input bit keep,
                     input logic [DW-1:0] rdat,
                     output bit won_d, output int gcyc);
    bit            ed;
    logic [AW-1:0] ea;
    logic          ewe;
    logic [DW-1:0] ewd;
    logic [MW-1:0] em;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    ed = d_req && !(if_req && streak >= LIM);
    @(negedge clk);
    chk("if_gnt", if_gnt, !ed);
    chk("d_gnt", d_gnt, ed);
    chk("arb_mreq", mem_req, 0);
    gcyc = cyc;
    if (!ed || !if_req) streak = 0;
    else if (streak < LIM) streak++;
    ea  = ed ? d_addr : if_addr;
    ewe = ed ? d_we : 1'b0;
    ewd = d_wdata;
    em  = ed ? d_wmask : '0;
    step();
    if (ed) begin
      if (keep) begin
        d_addr  = d_addr + 4;
        d_wdata = $urandom;
      end else d_req = 1'b0;
    end else begin
      if (keep) if_addr = if_addr + 4;
      else if_req = 1'b0;
    end
    for (int i = 0; i <= gd; i++) begin
      mem_gnt = (i == gd);
      @(negedge clk);
      chk("iss_req", mem_req, 1);
      chk("iss_addr", mem_addr, ea);
      chk("iss_we", mem_we, ewe);
      chk("iss_mask", mem_wmask, em);
      if (ed) chk("iss_wdata", mem_wdata, ewd);
      chk("iss_gnt", {if_gnt, d_gnt}, 0);
      chk("iss_rv", {if_rvalid, d_rvalid}, 0);
      step();
    end
    mem_gnt = 1'b0;
    for (int i = 0; i <= rd; i++) begin
      mem_rvalid = (i == rd);
      mem_rdata  = (i == rd) ? rdat : DW'($urandom);
      @(negedge clk);
      chk("wait_req", mem_req, 0);
      chk("wait_gnt", {if_gnt, d_gnt}, 0);
      chk("rv_if", if_rvalid, (i == rd) && !ed);
      chk("rv_d", d_rvalid, (i == rd) && ed);
      if (i == rd) chk("rdata", ed ? d_rdata : if_rdata, rdat);
      chk("spur", spurious_rsp, spur_exp);
      step();
    end
    mem_rvalid = 1'b0;
    won_d = ed;
  endtask

  initial begin
    bit        w;
    int        g0, g1, g2;
    logic [9:0] pat;
    logic [9:0] pat_exp;
    rst_n      = 1'b0;
    if_req     = 1'b1;
    if_addr    = 32'h200;
    d_req      = 1'b1;
    d_we       = 1'b0;
    d_addr     = 32'h40;
    d_wdata    = '0;
    d_wmask    = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", {if_gnt, d_gnt}, 0);
      chk("rst_mreq", mem_req, 0);
      chk("rst_rv", {if_rvalid, d_rvalid}, 0);
      chk("rst_spur", spurious_rsp, 0);
    end
    step();
    rst_n = 1'b1;

    // Tie at reset exit: data first, then the waiting fetch.
    txn(0, 0, 0, $urandom, w, g0);
    txn(0, 0, 0, $urandom, w, g0);

    // Fetch only, response two cycles after mem_gnt.
    if_req  = 1'b1;
    if_addr = 32'h100;
    txn(0, 1, 0, 32'h0000_0013, w, g0);

    // Both held: fetch must get through every LIM+1 grants.
    if_req  = 1'b1;
    if_addr = 32'h300;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h1000;
    pat     = '0;
    for (int i = 0; i < 10; i++) begin
      txn(0, 0, 1, $urandom, w, g0);
      pat[i] = w;
    end
    pat_exp = 10'b01111_01111;
    chk("starve_seq", pat, pat_exp);

    // Store under 5 cycles of backpressure, fetch waiting.
    d_we    = 1'b1;
    d_addr  = 32'h2000;
    d_wdata = 32'hCAFE_BABE;
    d_wmask = 4'b0011;
    txn(5, 0, 0, $urandom, w, g0);
    txn(0, 0, 0, $urandom, w, g0);

    // Back-to-back fetches with a 1-cycle memory.
    d_req   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0;
    txn(0, 0, 1, 32'hA0, w, g0);
    txn(0, 0, 1, 32'hA1, w, g1);
    txn(0, 0, 0, 32'hA2, w, g2);
    chk("b2b_gap1", g1 - g0, 3);
    chk("b2b_gap2", g2 - g1, 3);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if (!if_req && !d_req && $urandom_range(0, 2) == 0) idle_cyc();
      if (!if_req) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = $urandom;
      end
      if (!d_req) begin
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_wmask = MW'($urandom);
      end
      if (!if_req && !d_req) d_req = 1'b1;
      txn($urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), $urandom, w, g0);
    end

    // Reset while waiting for a response; the late response is spurious.
    if_req  = 1'b1;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h3000;
    d_wdata = 32'h1234_5678;
    d_wmask = 4'hF;
    step();
    d_req   = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_gnt", {if_gnt, d_gnt}, 0);
    chk("mid_rst_mreq", mem_req, 0);
    chk("mid_rst_rv", {if_rvalid, d_rvalid}, 0);
    @(posedge clk);
    #3;
    rst_n      = 1'b1;
    streak     = 0;
    if_req     = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    @(negedge clk);
    chk("late_rv", {if_rvalid, d_rvalid}, 0);
    chk("late_mreq", mem_req, 0);
    step();
    mem_rvalid = 1'b0;
    spur_exp   = 1'b1;
    idle_cyc();
    if_req  = 1'b1;
    if_addr = 32'h500;
    txn(1, 2, 0, $urandom, w, g0);
    repeat (3) idle_cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
